// File: rtl/root_5_en_iter_if.sv
// Operand/result bus of the iterative fifth-root extractor.
// master = operand producer / result consumer, slave = the extractor.
interface root_5_en_iter_if #(
    parameter int w  = 20,
    parameter int wr = (w + 4) / 5
);
    logic          x_vld;
    logic [w-1:0]  x;
    logic          x_rdy;
    logic          busy;
    logic          res_vld;
    logic [wr-1:0] res;

    modport master (
        output x_vld, x,
        input  x_rdy, busy, res_vld, res
    );

    modport slave (
        input  x_vld, x,
        output x_rdy, busy, res_vld, res
    );
endinterface

// File: rtl/root_5_en_iter.sv
// Iterative floor(x^(1/5)) by bit-serial binary search: each root bit costs one
// compare cycle plus four multiply cycles on a single shared multiplier.
module root_5_en_iter #(
    parameter int w  = 20,
    parameter int wr = (w + 4) / 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    root_5_en_iter_if.slave    bus
);
    localparam int AW = 5 * wr;
    localparam int BW = (wr > 1) ? $clog2(wr) : 1;
    localparam logic [wr-1:0] TOP_MASK = wr'(1) << (wr - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POW  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [w-1:0]  xq_q;
    logic [wr-1:0] r_q;
    logic [wr-1:0] res_q;
    logic [BW-1:0] b_q;
    logic [1:0]    k_q;
    logic [AW-1:0] acc_q;

    logic [wr-1:0] bit_mask_d;
    logic [wr-1:0] cand_d;
    logic [wr-1:0] r_d;
    logic [wr-1:0] next_cand_d;
    logic [AW-1:0] prod_d;
    logic          fits_d;

    // Candidate is the partial root with the bit under test forced to one.
    // cand < 2^wr, so cand^5 always fits in AW bits and truncation is lossless.
    always_comb begin
        bit_mask_d  = wr'(1) << b_q;
        cand_d      = r_q | bit_mask_d;
        prod_d      = acc_q * AW'(cand_d);
        fits_d      = (acc_q <= AW'(xq_q));
        r_d         = fits_d ? cand_d : r_q;
        next_cand_d = r_d | (bit_mask_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xq_q    <= '0;
            r_q     <= '0;
            res_q   <= '0;
            b_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (bus.x_vld) begin
                        xq_q    <= bus.x;
                        r_q     <= '0;
                        b_q     <= BW'(wr - 1);
                        acc_q   <= AW'(TOP_MASK);
                        k_q     <= '0;
                        state_q <= POW;
                    end
                end
                POW: begin
                    acc_q <= prod_d;
                    k_q   <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    r_q <= r_d;
                    if (b_q == '0) begin
                        res_q   <= r_d;
                        state_q <= DONE;
                    end else begin
                        b_q     <= b_q - BW'(1);
                        acc_q   <= AW'(next_cand_d);
                        k_q     <= '0;
                        state_q <= POW;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the registered state.
    assign bus.x_rdy   = (state_q == IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.res_vld = (state_q == DONE);
    assign bus.res     = res_q;
endmodule

// File: tb/tb_root_5_en_iter.sv
// Self-checking bench for root_5_en_iter: fixed vector table, hand-written
// abort/ignore sequences, and randomized operands against an arithmetic model.
module tb_root_5_en_iter;
    localparam int W  = 20;
    localparam int WR = (W + 4) / 5;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;

    root_5_en_iter_if #(.w(W), .wr(WR)) bus ();

    root_5_en_iter #(.w(W), .wr(WR)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [W-1:0] x;
        int           r;
        bit           rnd_en;
        bit           inject;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Largest r with r^5 <= v, by direct search over all possible roots.
    function automatic int root5(input longint v);
        int r = 0;
        for (int c = 1; c < 64; c++) begin
            longint p = longint'(c) * c * c * c * c;
            if (p <= v) r = c;
        end
        return r;
    endfunction

    task automatic wait_rdy(input string nm);
        int g = 0;
        while (!bus.x_rdy && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({nm, " x_rdy before accept"}, bus.x_rdy, 1);
    endtask

    task automatic do_op(input logic [W-1:0] xv, input int exp_r, input bit rnd,
                         input bit inject, input string nm);
        int   cnt;
        bit   seen;
        bit   en;
        logic [5:0] snap;
        wait_rdy(nm);
        bus.x     = xv;
        bus.x_vld = 1'b1;
        clk_en    = 1'b1;
        @(negedge clk);
        bus.x_vld = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (bus.res_vld) begin
                seen = 1'b1;
            end else begin
                check({nm, " busy/!x_rdy"}, {bus.busy, bus.x_rdy}, 2'b10);
                if (inject && cnt == 5) begin
                    bus.x     = 20'd7;
                    bus.x_vld = 1'b1;
                end
                if (inject && cnt == 9) bus.x_vld = 1'b0;
                en     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                clk_en = en;
                snap   = {bus.res_vld, bus.busy, bus.res};
                @(negedge clk);
                if (en) cnt++;
                else check({nm, " hold"}, {bus.res_vld, bus.busy, bus.res}, snap);
            end
        end
        bus.x_vld = 1'b0;
        check({nm, " res_vld seen"}, seen, 1);
        check({nm, " latency"}, cnt, 20);
        check({nm, " res"}, bus.res, exp_r);
        check({nm, " x_rdy in DONE"}, bus.x_rdy, 0);
        clk_en = 1'b0;
        @(negedge clk);
        check({nm, " res_vld held"}, bus.res_vld, 1);
        clk_en = 1'b1;
        @(negedge clk);
        check({nm, " res_vld one cycle"}, bus.res_vld, 0);
        check({nm, " res kept"}, bus.res, exp_r);
        $display("op %s: x=%0d res=%0d expected=%0d enabled_cycles=%0d", nm, xv, bus.res, exp_r, cnt);
    endtask

    initial begin
        int stray;
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        bus.x     = '0;
        bus.x_vld = 1'b0;

        vecs.push_back('{20'd0,       0,  1'b0, 1'b0});
        vecs.push_back('{20'd31,      1,  1'b0, 1'b0});
        vecs.push_back('{20'd32,      2,  1'b0, 1'b0});
        vecs.push_back('{20'd242,     2,  1'b0, 1'b0});
        vecs.push_back('{20'd243,     3,  1'b0, 1'b0});
        vecs.push_back('{20'd1023,    3,  1'b0, 1'b0});
        vecs.push_back('{20'd1024,    4,  1'b0, 1'b0});
        vecs.push_back('{20'd1048575, 15, 1'b0, 1'b0});
        vecs.push_back('{20'd759375,  15, 1'b0, 1'b0});
        vecs.push_back('{20'd759374,  14, 1'b0, 1'b0});
        vecs.push_back('{20'd100000,  10, 1'b1, 1'b0});
        vecs.push_back('{20'd99999,   9,  1'b1, 1'b0});
        vecs.push_back('{20'd243,     3,  1'b0, 1'b1});
        vecs.push_back('{20'd7,       1,  1'b0, 1'b0});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset busy", bus.busy, 0);
        check("reset x_rdy", bus.x_rdy, 1);
        check("reset res_vld", bus.res_vld, 0);
        check("reset res", bus.res, 0);

        foreach (vecs[i])
            do_op(vecs[i].x, vecs[i].r, vecs[i].rnd_en, vecs[i].inject, $sformatf("vec%0d", i));

        // Abort mid-computation with clk_en low at the reset edge.
        wait_rdy("abort");
        bus.x     = 20'd243;
        bus.x_vld = 1'b1;
        clk_en    = 1'b1;
        @(negedge clk);
        bus.x_vld = 1'b0;
        repeat (7) @(negedge clk);
        clk_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        clk_en = 1'b1;
        check("abort busy", bus.busy, 0);
        check("abort x_rdy", bus.x_rdy, 1);
        check("abort res_vld", bus.res_vld, 0);
        check("abort res", bus.res, 0);
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.res_vld) stray++;
        end
        check("abort stray res_vld", stray, 0);
        $display("op abort: res=%0d stray_pulses=%0d", bus.res, stray);
        do_op(20'd32, 2, 1'b0, 1'b0, "after_abort");

        // Randomized operands, half of them near exact fifth powers.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] xv;
            if (i % 2 == 0) begin
                xv = W'($urandom_range(0, 20'hFFFFF));
            end else begin
                int     rr = $urandom_range(0, 15);
                longint p  = longint'(rr) * rr * rr * rr * rr;
                longint d  = longint'($urandom_range(0, 2)) - 1;
                if (p + d < 0) d = 0;
                xv = W'(p + d);
            end
            do_op(xv, root5(longint'(xv)), (i % 3) == 0, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
